// File: rtl/ppu_palette_wr.sv
// CPU-writable 32-entry NES palette RAM with PPUADDR/PPUDATA register emulation
// and a ROM-compatible registered renderer read port.
module ppu_palette_wr #(
    parameter logic [5:0]  RST_COLOR = 6'h0F,
    parameter int unsigned ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_we,
    input  logic              cpu_rd,
    input  logic              cpu_reg,
    input  logic [7:0]        cpu_din,
    input  logic              inc32,
    input  logic              latch_clr,
    input  logic [4:0]        rd_addr,
    output logic [7:0]        rd_dout,
    output logic [7:0]        cpu_rd_data,
    output logic              cpu_rd_valid,
    output logic [ADDR_W-1:0] vaddr
);
    typedef enum logic {W_HIGH, W_LOW} wtog_t;

    localparam logic [ADDR_W-1:0] STEP1  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP32 = ADDR_W'(32);

    logic [5:0]        pal [32];
    wtog_t             w;
    logic              addr_wr;
    logic              data_wr;
    logic              data_rd;
    logic              in_pal;
    logic [ADDR_W-1:0] step;
    logic [4:0]        cpu_idx;
    logic [4:0]        rnd_idx;

    // Sprite backdrop entries 0x10/0x14/0x18/0x1C alias the background ones.
    function automatic logic [4:0] mirror(input logic [4:0] a);
        return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
    endfunction

    always_comb begin
        addr_wr = cpu_we && !cpu_reg;
        data_wr = cpu_we && cpu_reg;
        data_rd = cpu_rd && !cpu_we;
        in_pal  = (vaddr[ADDR_W-1:8] == (ADDR_W-8)'(6'h3F));
        step    = inc32 ? STEP32 : STEP1;
        cpu_idx = mirror(vaddr[4:0]);
        rnd_idx = mirror(rd_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                pal[i] <= RST_COLOR;
            end
            vaddr        <= '0;
            w            <= W_HIGH;
            rd_dout      <= '0;
            cpu_rd_data  <= '0;
            cpu_rd_valid <= 1'b0;
        end else begin
            rd_dout      <= {2'b00, pal[rnd_idx]};
            cpu_rd_valid <= data_rd;

            // A coincident latch_clr forces this address write to be the high byte.
            if (addr_wr) begin
                if (w == W_HIGH || latch_clr) begin
                    vaddr[ADDR_W-1:8] <= cpu_din[ADDR_W-9:0];
                    w                 <= W_LOW;
                end else begin
                    vaddr[7:0] <= cpu_din;
                    w          <= W_HIGH;
                end
            end else if (latch_clr) begin
                w <= W_HIGH;
            end

            if (data_wr) begin
                if (in_pal) begin
                    pal[cpu_idx] <= cpu_din[5:0];
                end
                vaddr <= vaddr + step;
            end

            if (data_rd) begin
                cpu_rd_data <= in_pal ? {2'b00, pal[cpu_idx]} : '0;
                vaddr       <= vaddr + step;
            end
        end
    end
endmodule

// File: tb/tb_ppu_palette_wr.sv
// Self-checking bench for ppu_palette_wr: directed scenarios plus random traffic
// compared against an array-based model of the PPU register behaviour.
module tb_ppu_palette_wr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_reg = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic        inc32 = 1'b0;
    logic        latch_clr = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [7:0]  rd_dout;
    logic [7:0]  cpu_rd_data;
    logic        cpu_rd_valid;
    logic [13:0] vaddr;

    ppu_palette_wr #(.RST_COLOR(6'h0F), .ADDR_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
        .cpu_reg(cpu_reg), .cpu_din(cpu_din), .inc32(inc32),
        .latch_clr(latch_clr), .rd_addr(rd_addr), .rd_dout(rd_dout),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid), .vaddr(vaddr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: palette contents, address register, write toggle.
    int mpal [32];
    int mva;
    bit mw;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mir(input int a);
        return (a >= 16 && (a % 4) == 0) ? a - 16 : a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mpal[i] = 'h0F;
        mva = 0;
        mw  = 0;
    endtask

    // Drive one cycle, predict from the model, sample #1 after the edge.
    task automatic step(input bit we, input bit rd, input bit rg, input int din,
                        input bit i32, input bit clr, input int ra);
        int exp_rd, exp_data, inc;
        bit exp_valid;
        cpu_we = we; cpu_rd = rd; cpu_reg = rg; cpu_din = 8'(din);
        inc32 = i32; latch_clr = clr; rd_addr = 5'(ra);

        exp_rd    = mpal[mir(ra % 32)];
        exp_valid = rd && !we;
        exp_data  = 0;
        inc       = i32 ? 32 : 1;
        if (exp_valid && (mva / 256) == 'h3F) exp_data = mpal[mir(mva % 32)];
        if (we && !rg) begin
            if (clr || !mw) begin
                mva = (mva % 256) + (din % 64) * 256;
                mw  = 1;
            end else begin
                mva = (mva / 256) * 256 + (din % 256);
                mw  = 0;
            end
        end else if (clr) begin
            mw = 0;
        end
        if (we && rg) begin
            if ((mva / 256) == 'h3F) mpal[mir(mva % 32)] = din % 64;
            mva = (mva + inc) % 16384;
        end
        if (exp_valid) mva = (mva + inc) % 16384;

        @(posedge clk);
        #1;
        check("rd_dout", rd_dout, exp_rd);
        check("cpu_rd_valid", cpu_rd_valid, exp_valid);
        if (exp_valid) check("cpu_rd_data", cpu_rd_data, exp_data);
        check("vaddr", vaddr, mva);
        cpu_we = 0; cpu_rd = 0; latch_clr = 0;
    endtask

    task automatic set_addr(input int hi, input int lo);
        step(1, 0, 0, hi, 0, 1, 0);
        step(1, 0, 0, lo, 0, 0, 0);
    endtask

    task automatic wr_data(input int d, input bit i32, input int ra);
        step(1, 0, 1, d, i32, 0, ra);
    endtask

    initial begin
        model_reset();
        #2;
        check("reset_rd_dout", rd_dout, 0);
        check("reset_valid", cpu_rd_valid, 0);
        check("reset_rd_data", cpu_rd_data, 0);
        check("reset_vaddr", vaddr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) step(0, 0, 0, 0, 0, 0, a);
        check("sweep_last", rd_dout, 'h0F);

        set_addr('h3F, 'h00);
        wr_data('h11, 0, 0);
        wr_data('h21, 0, 0);
        wr_data('h30, 0, 0);
        check("vaddr_3f03", vaddr, 'h3F03);
        step(0, 0, 0, 0, 0, 0, 'h01);
        check("entry1", rd_dout, 'h21);

        set_addr('h3F, 'h10);
        wr_data('h2A, 0, 0);
        step(0, 0, 0, 0, 0, 0, 'h00);
        check("mirror_00", rd_dout, 'h2A);
        step(0, 0, 0, 0, 0, 0, 'h10);
        check("mirror_10", rd_dout, 'h2A);
        set_addr('h3F, 'h11);
        wr_data('h15, 0, 0);
        step(0, 0, 0, 0, 0, 0, 'h11);
        check("entry11", rd_dout, 'h15);
        step(0, 0, 0, 0, 0, 0, 'h01);
        check("entry01_kept", rd_dout, 'h21);

        step(1, 0, 0, 'h3F, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 'h3F, 0, 0, 0);
        step(1, 0, 0, 'h05, 0, 0, 0);
        check("toggle_clear", vaddr, 'h3F05);
        step(1, 0, 0, 'h3F, 0, 0, 0);
        step(1, 0, 0, 'h20, 0, 1, 0);
        check("clr_hi_byte", int'(vaddr[13:8]), 'h20);
        step(1, 0, 0, 'h34, 0, 0, 0);
        check("w_left_set", vaddr, 'h2034);

        set_addr('h20, 'h00);
        wr_data('h3C, 0, 0);
        check("nonpal_inc", vaddr, 'h2001);
        set_addr('h3F, 'hFF);
        wr_data('h01, 0, 0);
        check("wrap_inc1", vaddr, 'h0000);
        set_addr('h3F, 'hE0);
        wr_data('h02, 1, 0);
        check("wrap_inc32", vaddr, 'h0000);
        set_addr('h20, 'h05);
        step(0, 1, 0, 0, 0, 0, 0);
        check("nonpal_rd_valid", cpu_rd_valid, 1);
        check("nonpal_rd_data", cpu_rd_data, 0);

        set_addr('h3F, 'h19);
        wr_data('h06, 0, 'h19);
        step(0, 0, 0, 0, 0, 0, 'h19);
        check("collision_new", rd_dout, 'h06);
        set_addr('h3F, 'h00);
        step(1, 1, 1, 'h0A, 0, 0, 0);
        check("we_rd_no_valid", cpu_rd_valid, 0);
        check("we_rd_single_inc", vaddr, 'h3F01);

        set_addr('h3F, 'h04);
        wr_data('h07, 0, 0);
        set_addr('h3F, 'h14);
        step(0, 1, 0, 0, 0, 0, 0);
        check("rd_after_wr", cpu_rd_data, 'h07);

        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_rd_dout", rd_dout, 0);
        check("midrst_valid", cpu_rd_valid, 0);
        check("midrst_rd_data", cpu_rd_data, 0);
        check("midrst_vaddr", vaddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) step(0, 0, 0, 0, 0, 0, a);

        for (int n = 0; n < 3000; n++) begin
            bit we, rd, rg, i32, clr;
            int din;
            we  = $urandom_range(0, 1) == 1;
            rd  = $urandom_range(0, 2) == 0;
            rg  = $urandom_range(0, 1) == 1;
            i32 = $urandom_range(0, 3) == 0;
            clr = $urandom_range(0, 9) == 0;
            din = int'($urandom_range(0, 255));
            if (we && !rg && (!mw || clr) && $urandom_range(0, 2) != 0) din = 'h3F;
            step(we, rd, rg, din, i32, clr, int'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ppu_palette_wr.md
Name: ppu_palette_wr

Overview:
CPU-side write/read end of the PPU palette memory, replacing the fixed palette ROM with a writable 32-entry palette RAM. It emulates the PPUADDR ($2006) two-write address latch and the PPUDATA ($2007) data port with auto-increment, and applies NES palette mirroring. It also provides a renderer read port that behaves like the palette ROM: 5-bit address in, 8-bit data out one clock later.

Parameters:
RST_COLOR, 6'h0F, value loaded into every palette entry at reset
ADDR_W, 14, width of the PPU address register

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_we  in  1  one-cycle register write strobe
cpu_rd  in  1  one-cycle PPUDATA read strobe
cpu_reg  in  1  0 = PPUADDR, 1 = PPUDATA (qualifies cpu_we only)
cpu_din  in  8  CPU write data
inc32  in  1  address increment: 0 = +1, 1 = +32
latch_clr  in  1  clears the address write toggle (PPUSTATUS read side effect)
rd_addr  in  5  renderer palette address
rd_dout  out  8  renderer palette data, registered, 1-cycle latency
cpu_rd_data  out  8  PPUDATA read result
cpu_rd_valid  out  1  one-cycle pulse; cpu_rd_data valid
vaddr  out  14  current PPU address register

Behaviour:
- Reset (async, rst_n=0): all 32 entries = RST_COLOR; vaddr=0; toggle w=0; rd_dout=0; cpu_rd_data=0; cpu_rd_valid=0. Reset mid-sequence discards any half-written address.
- Palette storage: 32x6 bits. Reads return {2'b00, entry}. Writes store cpu_din[5:0].
- Mirror function m(a): if a[4]=1 and a[1:0]=00, then idx = {1'b0, a[3:0]}; else idx = a. Consequently 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C. m() applies to the CPU and renderer paths alike.
- PPUADDR write (cpu_we=1, cpu_reg=0):
  - w=0: vaddr[13:8] <= cpu_din[5:0]; vaddr[7:0] holds; w <= 1.
  - w=1: vaddr[7:0] <= cpu_din; w <= 0.
- latch_clr=1: w <= 0. If it coincides with a PPUADDR write, the clear is applied first and the write is handled as a w=0 (high-byte) write, leaving w=1.
- PPUDATA write (cpu_we=1, cpu_reg=1):
  - If vaddr[13:8]==6'h3F, entry m(vaddr[4:0]) <= cpu_din[5:0]. Otherwise there is no palette write.
  - In both cases vaddr <= vaddr + (inc32 ? 32 : 1), modulo 2^14 (0x3FFF+1 wraps to 0x0000).
  - w is unaffected.
- PPUDATA read (cpu_rd=1, cpu_we=0):
  - Next cycle: cpu_rd_valid=1, and cpu_rd_data = palette[m(vaddr[4:0])] if vaddr[13:8]==6'h3F, else 8'h00.
  - vaddr increments as for a write.
  - cpu_rd_valid=0 on all other cycles.
- cpu_we and cpu_rd in the same cycle: the write executes; the read is ignored (no valid pulse, single increment).
- Renderer port: rd_dout <= {2'b00, palette[m(rd_addr)]} every cycle; latency exactly 1 clock.
- Same-cycle renderer read and CPU write to the same (mirrored) entry: rd_dout returns the old value. The new value is visible from the following read.
- CPU read in the cycle after a write to the same entry returns the new value.
- No FSM beyond the w toggle. All state is on clk rising edge or rst_n falling edge.

Test Plan:
- Reset, then rd_addr=0x00..0x1F swept → rd_dout=8'h0F for every address, each appearing 1 cycle after its address; vaddr=0.
- PPUADDR writes 0x3F, 0x00; then PPUDATA writes 0x11, 0x21, 0x30 with inc32=0 → entries 0, 1, 2 = 0x11, 0x21, 0x30; vaddr=0x3F03; renderer read of 0x01 gives 0x21.
- Mirroring: vaddr=0x3F10, write 0x2A → rd_addr=0x00 and rd_addr=0x10 both give 0x2A. Write 0x15 at vaddr 0x3F11 → entry 0x11=0x15, entry 0x01 unchanged.
- Toggle and clear: PPUADDR write 0x3F, then latch_clr=1, then PPUADDR writes 0x3F, 0x05 → vaddr=0x3F05. A same-cycle latch_clr + PPUADDR 0x20 write leaves vaddr[13:8]=0x20, w=1.
- Non-palette region and wrap: vaddr=0x2000, PPUDATA write 0x3C → no palette change, vaddr=0x2001. vaddr=0x3FFF with inc32=0 → 0x0000. vaddr=0x3FE0 with inc32=1 → 0x0000. cpu_rd at 0x2005 → cpu_rd_valid pulse with cpu_rd_data=0x00.
- Collision and priority: same-cycle write of 0x06 to entry 0x19 and rd_addr=0x19 → old value out, 0x06 on the next read. cpu_we+cpu_rd together → no cpu_rd_valid, vaddr incremented once. rst_n pulsed low mid-sequence → all outputs and entries return to reset values immediately.
